risc_seq_ctrl: RTL and testbench
================================

Name: risc_seq_ctrl

Overview:
Multi-cycle control sequencer for the KGP-RISC datapath. Owns the PC and the instruction/data-memory handshakes, decodes opcode/funccode, and drives the datapath control strobes (reg_dest, reg_write, ALUop, ALUsource, mem_write, mem_to_reg, branch) one state at a time. Sits beside the datapath in the processor top; resolves branches from the datapath's zero/sign/carry flags.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment to the next sequential instruction.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  leave IDLE and begin fetching at pc
opcode  in  6  decoded opcode of the latched instruction
funccode  in  6  decoded function code
offset  in  16  immediate/branch offset field
pda  in  26  pseudo-direct jump field
zero, sign, carry  in  1 each  datapath ALU flags (carry is the registered previous carry)
imem_req  out  1  instruction fetch request at pc
imem_ack  in  1  fetch data valid; instruction latched this cycle
ir_load  out  1  one-cycle strobe to latch the instruction word
dmem_req  out  1  data-memory access request
dmem_ack  in  1  data-memory access complete
pc  out  32  current program counter
reg_dest  out  2  0=rs, 1=rt, 2=R31
reg_write  out  1  register-file write strobe
ALUop  out  3  ALU operation
ALUsource  out  2  0=rt, 1=offset, 2=shamt
mem_write  out  1  store strobe
mem_to_reg  out  2  0=ALU result, 1=memRead, 2=nextPC
branch  out  3  resolved branch code, 0=none
busy  out  1  high in any state other than IDLE/HALT
halted  out  1  high in HALT

Behaviour:
- Reset (async, any state, mid-access included): state=IDLE, pc=RESET_PC, every other output 0; outstanding requests dropped.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH; otherwise hold.
- FETCH: imem_req=1 until imem_ack; ack in the same cycle as req is legal. On ack, ir_load=1 for one cycle -> DECODE.
- DECODE: classifies the instruction, drives nothing -> EXEC; opcode 6'h3F -> HALT.
- Opcode classes: 6'h00 R-type, ALUop=funccode[2:0], ALUsource=funccode[3]?2:0. 6'h08-6'h0F ALU-imm, ALUop=opcode[2:0], ALUsource=1. 6'h02 load. 6'h03 store. 6'h04 jump. 6'h05 conditional branch. 6'h06 call. Any other opcode executes as a NOP.
- EXEC: holds ALU controls. R/ALU-imm -> WB. Load/store: ALUop=ADD, ALUsource=1 -> MEM.
- Conditional branch: funccode 0=bz(zero), 1=bnz(!zero), 2=bltz(sign), 3=bgez(!sign), 4=bcy(carry), 5=bncy(!carry); other codes are never taken. Flags are sampled in EXEC. branch = funccode[2:0]+1 during EXEC.
- Branch target: pc+PC_STEP+(sign-extended offset<<2). The 32-bit add wraps modulo 2^32.
- Jump/call target: {pc[31:28],pda,2'b00}. Call -> WB; branch/jump -> FETCH.
- MEM: dmem_req=1 until dmem_ack. Store: mem_write=1 in the ack cycle only -> FETCH. Load -> WB.
- WB: reg_write=1 for exactly one cycle. R/imm: reg_dest=0, mem_to_reg=0. Load: reg_dest=1, mem_to_reg=1. Call: reg_dest=2, mem_to_reg=2. -> FETCH.
- PC update: pc advances by PC_STEP on the last cycle of each non-branching instruction (the WB cycle, or MEM for a store). Taken branch/jump/call loads the target in its final cycle. Not-taken branch advances by PC_STEP in EXEC. Wrap at 2^32 is silent.
- Zero-wait latencies, counted FETCH to next FETCH: R/imm 4, load 5, store 4, branch/jump 3, call 4.
- HALT: all strobes 0, pc frozen; only rst exits. start is ignored outside IDLE. Acks arriving without a matching request are ignored.

Optional Feature:
RISC_SEQ_PERF_EN:
- Defined: adds outputs cycle_cnt[31:0] (increments every cycle while busy) and retired_cnt[31:0] (increments when an instruction completes, including NOPs, excluding halt). Both reset to 0 and wrap.
- Undefined: ports and logic are absent.

Decomposition:
- Package risc_seq_pkg holds the state enum, opcode class constants, branch condition codes, and the ALUsource/mem_to_reg/reg_dest encodings.
- One sub-module, risc_branch_eval: combinational condition and target computation (funccode, flags, pc, offset, pda -> taken, target).

Test Plan:
- Reset during FETCH with imem_req high -> next cycle pc=0, imem_req=0, state IDLE; start then refetches at pc=0.
- R-type ADD, zero-wait acks -> reg_write pulses in cycle 4, reg_dest=0, mem_to_reg=0; pc 0->4.
- Load with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, then WB with mem_to_reg=1, reg_dest=1.
- bz, pc=0x100, offset=16'hFFFE: zero=1 -> pc=0x0FC; repeated with zero=0 -> pc=0x104.
- Call, pc=0xF000_0010, pda=26'h40 -> R31 written via mem_to_reg=2 in WB; pc=0xF000_0100.
- Opcode 6'h3F -> halted=1, pc frozen for 20 cycles, start ignored; with RISC_SEQ_PERF_EN, retired_cnt unchanged.

Source files
------------

// File: rtl/risc_seq_pkg.sv
// Shared types and encodings for the KGP-RISC control sequencer:
// FSM states, instruction classes, opcodes, branch conditions and mux selects.
package risc_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_RTYPE, C_ALUI, C_LOAD, C_STORE, C_JUMP, C_BRANCH, C_CALL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_LOAD   = 6'h02;
   localparam logic [5:0] OP_STORE  = 6'h03;
   localparam logic [5:0] OP_JUMP   = 6'h04;
   localparam logic [5:0] OP_BRANCH = 6'h05;
   localparam logic [5:0] OP_CALL   = 6'h06;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   localparam logic [5:0] BC_BZ   = 6'd0;
   localparam logic [5:0] BC_BNZ  = 6'd1;
   localparam logic [5:0] BC_BLTZ = 6'd2;
   localparam logic [5:0] BC_BGEZ = 6'd3;
   localparam logic [5:0] BC_BCY  = 6'd4;
   localparam logic [5:0] BC_BNCY = 6'd5;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [1:0] SRC_RT    = 2'd0;
   localparam logic [1:0] SRC_IMM   = 2'd1;
   localparam logic [1:0] SRC_SHAMT = 2'd2;
   localparam logic [1:0] M2R_ALU   = 2'd0;
   localparam logic [1:0] M2R_MEM   = 2'd1;
   localparam logic [1:0] M2R_NPC   = 2'd2;
   localparam logic [1:0] RD_RS     = 2'd0;
   localparam logic [1:0] RD_RT     = 2'd1;
   localparam logic [1:0] RD_R31    = 2'd2;

   // Halt is not a class; DECODE tests for it before classifying.
   function automatic iclass_t classify(input logic [5:0] op);
      iclass_t c;
      c = C_NOP;
      if (op[5:3] == 3'b001) begin
         c = C_ALUI;
      end else begin
         case (op)
            OP_RTYPE:  c = C_RTYPE;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_JUMP:   c = C_JUMP;
            OP_BRANCH: c = C_BRANCH;
            OP_CALL:   c = C_CALL;
            default:   c = C_NOP;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/risc_seq_ctrl_branch_eval.sv
// Combinational branch resolution: condition from ALU flags, PC-relative
// branch target and pseudo-direct jump/call target.
module risc_branch_eval
   import risc_seq_pkg::*;
#(
   parameter logic [31:0] PC_STEP = 32'd4
) (
   input  logic [5:0]  i_funccode,
   input  logic        i_zero,
   input  logic        i_sign,
   input  logic        i_carry,
   input  logic [31:0] i_pc,
   input  logic [15:0] i_offset,
   input  logic [25:0] i_pda,
   output logic        o_taken,
   output logic [31:0] o_br_target,
   output logic [31:0] o_jmp_target
);

   logic [31:0] w_br_off;

   always_comb begin
      o_taken = 1'b0;
      case (i_funccode)
         BC_BZ:   o_taken = i_zero;
         BC_BNZ:  o_taken = ~i_zero;
         BC_BLTZ: o_taken = i_sign;
         BC_BGEZ: o_taken = ~i_sign;
         BC_BCY:  o_taken = i_carry;
         BC_BNCY: o_taken = ~i_carry;
         default: o_taken = 1'b0;
      endcase
   end

   assign w_br_off     = {{14{i_offset[15]}}, i_offset, 2'b00};
   assign o_br_target  = i_pc + PC_STEP + w_br_off;
   assign o_jmp_target = {i_pc[31:28], i_pda, 2'b00};

endmodule

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle KGP-RISC control sequencer: owns PC, memory handshakes and control strobes.
// Optional RISC_SEQ_PERF_EN adds busy-cycle and retired-instruction counters.
module risc_seq_ctrl
   import risc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_funccode,
   input  logic [15:0] i_offset,
   input  logic [25:0] i_pda,
   input  logic        i_zero,
   input  logic        i_sign,
   input  logic        i_carry,
   output logic        o_imem_req,
   input  logic        i_imem_ack,
   output logic        o_ir_load,
   output logic        o_dmem_req,
   input  logic        i_dmem_ack,
   output logic [31:0] o_pc,
   output logic [1:0]  o_reg_dest,
   output logic        o_reg_write,
   output logic [2:0]  o_ALUop,
   output logic [1:0]  o_ALUsource,
   output logic        o_mem_write,
   output logic [1:0]  o_mem_to_reg,
   output logic [2:0]  o_branch,
`ifdef RISC_SEQ_PERF_EN
   output logic [31:0] o_cycle_cnt,
   output logic [31:0] o_retired_cnt,
`endif
   output logic        o_busy,
   output logic        o_halted
);

   state_t      r_state;
   iclass_t     r_cls;
   logic [31:0] r_pc;
   logic        r_imem_req, r_dmem_req, r_reg_write;
   logic [1:0]  r_reg_dest, r_alu_src, r_mem_to_reg;
   logic [2:0]  r_alu_op, r_branch;

   logic        w_taken;
   logic [31:0] w_br_target, w_jmp_target, w_pc_next;
   logic        w_mem_done;

   assign w_pc_next  = r_pc + PC_STEP;
   assign w_mem_done = (r_state == S_MEM) && i_dmem_ack;

   risc_branch_eval #(.PC_STEP(PC_STEP)) u_branch_eval (
      .i_funccode   (i_funccode),
      .i_zero       (i_zero),
      .i_sign       (i_sign),
      .i_carry      (i_carry),
      .i_pc         (r_pc),
      .i_offset     (i_offset),
      .i_pda        (i_pda),
      .o_taken      (w_taken),
      .o_br_target  (w_br_target),
      .o_jmp_target (w_jmp_target)
   );

   // Outputs are registered on entry to the state that owns them; ALU
   // controls stay up through MEM/WB so the result path is stable at write.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cls        <= C_NOP;
         r_pc         <= RESET_PC;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_reg_write  <= 1'b0;
         r_reg_dest   <= RD_RS;
         r_alu_src    <= SRC_RT;
         r_mem_to_reg <= M2R_ALU;
         r_alu_op     <= 3'd0;
         r_branch     <= 3'd0;
      end else begin
         r_reg_write <= 1'b0;
         r_branch    <= 3'd0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (i_imem_ack) begin
                  r_state    <= S_DECODE;
                  r_imem_req <= 1'b0;
               end
            end
            S_DECODE: begin
               if (i_opcode == OP_HALT) begin
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
                  r_cls   <= classify(i_opcode);
                  case (classify(i_opcode))
                     C_RTYPE: begin
                        r_alu_op  <= i_funccode[2:0];
                        r_alu_src <= i_funccode[3] ? SRC_SHAMT : SRC_RT;
                     end
                     C_ALUI: begin
                        r_alu_op  <= i_opcode[2:0];
                        r_alu_src <= SRC_IMM;
                     end
                     C_LOAD, C_STORE: begin
                        r_alu_op  <= ALU_ADD;
                        r_alu_src <= SRC_IMM;
                     end
                     C_BRANCH: r_branch <= i_funccode[2:0] + 3'd1;
                     default: ;
                  endcase
               end
            end
            S_EXEC: begin
               case (r_cls)
                  C_RTYPE, C_ALUI: begin
                     r_state      <= S_WB;
                     r_reg_write  <= 1'b1;
                     r_reg_dest   <= RD_RS;
                     r_mem_to_reg <= M2R_ALU;
                  end
                  C_LOAD, C_STORE: begin
                     r_state    <= S_MEM;
                     r_dmem_req <= 1'b1;
                  end
                  C_CALL: begin
                     r_state      <= S_WB;
                     r_reg_write  <= 1'b1;
                     r_reg_dest   <= RD_R31;
                     r_mem_to_reg <= M2R_NPC;
                  end
                  default: begin
                     r_state    <= S_FETCH;
                     r_imem_req <= 1'b1;
                     r_alu_op   <= 3'd0;
                     r_alu_src  <= SRC_RT;
                     if (r_cls == C_JUMP)
                        r_pc <= w_jmp_target;
                     else if (r_cls == C_BRANCH && w_taken)
                        r_pc <= w_br_target;
                     else
                        r_pc <= w_pc_next;
                  end
               endcase
            end
            S_MEM: begin
               if (i_dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  if (r_cls == C_STORE) begin
                     r_state    <= S_FETCH;
                     r_imem_req <= 1'b1;
                     r_pc       <= w_pc_next;
                     r_alu_op   <= 3'd0;
                     r_alu_src  <= SRC_RT;
                  end else begin
                     r_state      <= S_WB;
                     r_reg_write  <= 1'b1;
                     r_reg_dest   <= RD_RT;
                     r_mem_to_reg <= M2R_MEM;
                  end
               end
            end
            S_WB: begin
               r_state      <= S_FETCH;
               r_imem_req   <= 1'b1;
               r_pc         <= (r_cls == C_CALL) ? w_jmp_target : w_pc_next;
               r_alu_op     <= 3'd0;
               r_alu_src    <= SRC_RT;
               r_reg_dest   <= RD_RS;
               r_mem_to_reg <= M2R_ALU;
            end
            S_HALT: ;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The datapath latches IR and store data in the ack cycle itself.
   assign o_ir_load    = (r_state == S_FETCH) && i_imem_ack;
   assign o_mem_write  = w_mem_done && (r_cls == C_STORE);
   assign o_imem_req   = r_imem_req;
   assign o_dmem_req   = r_dmem_req;
   assign o_pc         = r_pc;
   assign o_reg_dest   = r_reg_dest;
   assign o_reg_write  = r_reg_write;
   assign o_ALUop      = r_alu_op;
   assign o_ALUsource  = r_alu_src;
   assign o_mem_to_reg = r_mem_to_reg;
   assign o_branch     = r_branch;
   assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
   assign o_halted     = (r_state == S_HALT);

`ifdef RISC_SEQ_PERF_EN
   logic        w_retire;
   logic [31:0] r_cycle_cnt, r_retired_cnt;

   assign w_retire = (r_state == S_WB) || o_mem_write ||
                     ((r_state == S_EXEC) &&
                      (r_cls == C_JUMP || r_cls == C_BRANCH || r_cls == C_NOP));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cycle_cnt   <= 32'd0;
         r_retired_cnt <= 32'd0;
      end else begin
         if (o_busy)
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_retire)
            r_retired_cnt <= r_retired_cnt + 32'd1;
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Directed self-checking bench for risc_seq_ctrl.
module tb_risc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  opcode = '0;
   logic [5:0]  funccode = '0;
   logic [15:0] offset = '0;
   logic [25:0] pda = '0;
   logic        zero = 1'b0, sign = 1'b0, carry = 1'b0;
   logic        imem_req, imem_ack = 1'b0, ir_load;
   logic        dmem_req, dmem_ack = 1'b0;
   logic [31:0] pc;
   logic [1:0]  reg_dest, ALUsource, mem_to_reg;
   logic        reg_write, mem_write, busy, halted;
   logic [2:0]  ALUop, branch;
`ifdef RISC_SEQ_PERF_EN
   logic [31:0] cycle_cnt, retired_cnt;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   risc_seq_ctrl dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_opcode     (opcode),
      .i_funccode   (funccode),
      .i_offset     (offset),
      .i_pda        (pda),
      .i_zero       (zero),
      .i_sign       (sign),
      .i_carry      (carry),
      .o_imem_req   (imem_req),
      .i_imem_ack   (imem_ack),
      .o_ir_load    (ir_load),
      .o_dmem_req   (dmem_req),
      .i_dmem_ack   (dmem_ack),
      .o_pc         (pc),
      .o_reg_dest   (reg_dest),
      .o_reg_write  (reg_write),
      .o_ALUop      (ALUop),
      .o_ALUsource  (ALUsource),
      .o_mem_write  (mem_write),
      .o_mem_to_reg (mem_to_reg),
      .o_branch     (branch),
`ifdef RISC_SEQ_PERF_EN
      .o_cycle_cnt  (cycle_cnt),
      .o_retired_cnt(retired_cnt),
`endif
      .o_busy       (busy),
      .o_halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then start: returns with the DUT in FETCH at pc=0.
   task automatic boot();
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      zero = 1'b0; sign = 1'b0; carry = 1'b0;
      tick();
      rst = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Zero-wait fetch of one instruction: returns in DECODE.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fc,
                        input logic [15:0] off, input logic [25:0] p);
      opcode = op; funccode = fc; offset = off; pda = p;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
      n_cmp++; if ({busy, halted, reg_write, dmem_req} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {busy, halted, reg_write, dmem_req}); end
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL start_fetch_req: got %b want 1", imem_req); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_rst_req: got %b want 0", imem_req); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midfetch_rst_busy: got %b want 0", busy); end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_hold_req: got %b want 0", imem_req); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL refetch: got req=%b pc=%h want req=1 pc=0", imem_req, pc); end
   endtask

   task automatic test_rtype();
      boot();
      opcode = 6'h00; funccode = 6'h00; imem_ack = 1'b1;
      #1;
      n_cmp++; if (ir_load !== 1'b1) begin n_fail++; $display("FAIL ir_load_ack: got %b want 1", ir_load); end
      tick();
      imem_ack = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL decode_quiet: got req=%b rw=%b want 0 0", imem_req, reg_write); end
      tick();
      n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL add_exec_rw: got %b want 0", reg_write); end
      tick();
      n_cmp++; if ({reg_write, reg_dest, mem_to_reg} !== 5'b1_00_00) begin n_fail++; $display("FAIL add_wb: got rw=%b rd=%0d m2r=%0d want 1 0 0", reg_write, reg_dest, mem_to_reg); end
      n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL add_wb_pc: got %h want %h", pc, 32'h0); end
      tick();
      n_cmp++; if (pc !== 32'h4 || reg_write !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL add_done: got pc=%h rw=%b req=%b want 4 0 1", pc, reg_write, imem_req); end
      // Fetch with two wait cycles, shamt-sourced R-type.
      tick(); tick();
      n_cmp++; if (imem_req !== 1'b1 || ir_load !== 1'b0) begin n_fail++; $display("FAIL fetch_wait: got req=%b irl=%b want 1 0", imem_req, ir_load); end
      fetch(6'h00, 6'h0B, 16'h0, 26'h0);
      tick();
      n_cmp++; if (ALUop !== 3'd3 || ALUsource !== 2'd2) begin n_fail++; $display("FAIL shamt_exec: got op=%0d src=%0d want 3 2", ALUop, ALUsource); end
      tick(); tick();
      n_cmp++; if (pc !== 32'h8) begin n_fail++; $display("FAIL shamt_pc: got %h want %h", pc, 32'h8); end
      fetch(6'h0D, 6'h00, 16'h0, 26'h0);
      tick();
      n_cmp++; if (ALUop !== 3'd5 || ALUsource !== 2'd1) begin n_fail++; $display("FAIL imm_exec: got op=%0d src=%0d want 5 1", ALUop, ALUsource); end
      tick();
      n_cmp++; if (reg_write !== 1'b1 || mem_to_reg !== 2'd0) begin n_fail++; $display("FAIL imm_wb: got rw=%b m2r=%0d want 1 0", reg_write, mem_to_reg); end
      tick();
      n_cmp++; if (pc !== 32'hC) begin n_fail++; $display("FAIL imm_pc: got %h want %h", pc, 32'hC); end
   endtask

   task automatic test_load_store();
      boot();
      fetch(6'h02, 6'h00, 16'h0, 26'h0);
      tick();
      n_cmp++; if (ALUop !== 3'd0 || ALUsource !== 2'd1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_exec: got op=%0d src=%0d dreq=%b want 0 1 0", ALUop, ALUsource, dmem_req); end
      tick();
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL ld_dreq_%0d: got %b want 1", i, dmem_req); end
         if (i == 3) dmem_ack = 1'b1;
         #1;
         n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL ld_no_mw_%0d: got %b want 0", i, mem_write); end
         tick();
      end
      dmem_ack = 1'b0;
      n_cmp++; if ({dmem_req, reg_write, reg_dest, mem_to_reg} !== 6'b0_1_01_01) begin n_fail++; $display("FAIL ld_wb: got dreq=%b rw=%b rd=%0d m2r=%0d want 0 1 1 1", dmem_req, reg_write, reg_dest, mem_to_reg); end
      tick();
      n_cmp++; if (pc !== 32'h4 || reg_write !== 1'b0) begin n_fail++; $display("FAIL ld_done: got pc=%h rw=%b want 4 0", pc, reg_write); end
      fetch(6'h03, 6'h00, 16'h0, 26'h0);
      tick(); tick();
      n_cmp++; if (mem_write !== 1'b0 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_wait: got mw=%b dreq=%b want 0 1", mem_write, dmem_req); end
      dmem_ack = 1'b1;
      #1;
      n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL st_ack_mw: got %b want 1", mem_write); end
      tick();
      dmem_ack = 1'b0;
      n_cmp++; if (mem_write !== 1'b0 || pc !== 32'h8 || imem_req !== 1'b1 || reg_write !== 1'b0) begin n_fail++; $display("FAIL st_done: got mw=%b pc=%h req=%b rw=%b want 0 8 1 0", mem_write, pc, imem_req, reg_write); end
   endtask

   task automatic test_branch();
      boot();
      fetch(6'h04, 6'h00, 16'h0, 26'h40);
      tick();
      n_cmp++; if (branch !== 3'd0) begin n_fail++; $display("FAIL jmp_branch: got %0d want 0", branch); end
      tick();
      n_cmp++; if (pc !== 32'h100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL jmp_pc: got pc=%h req=%b want 100 1", pc, imem_req); end
      zero = 1'b1;
      fetch(6'h05, 6'h00, 16'hFFFE, 26'h0);
      tick();
      n_cmp++; if (branch !== 3'd1) begin n_fail++; $display("FAIL bz_code: got %0d want 1", branch); end
      tick();
      n_cmp++; if (pc !== 32'h0FC) begin n_fail++; $display("FAIL bz_taken_pc: got %h want %h", pc, 32'h0FC); end
      fetch(6'h04, 6'h00, 16'h0, 26'h40);
      tick(); tick();
      zero = 1'b0;
      fetch(6'h05, 6'h00, 16'hFFFE, 26'h0);
      tick(); tick();
      n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL bz_not_taken_pc: got %h want %h", pc, 32'h104); end
      carry = 1'b1;
      fetch(6'h05, 6'h05, 16'h0010, 26'h0);
      tick();
      n_cmp++; if (branch !== 3'd6) begin n_fail++; $display("FAIL bncy_code: got %0d want 6", branch); end
      tick();
      n_cmp++; if (pc !== 32'h108) begin n_fail++; $display("FAIL bncy_pc: got %h want %h", pc, 32'h108); end
      carry = 1'b0; sign = 1'b1;
      fetch(6'h05, 6'h02, 16'h0010, 26'h0);
      tick(); tick();
      n_cmp++; if (pc !== 32'h14C) begin n_fail++; $display("FAIL bltz_pc: got %h want %h", pc, 32'h14C); end
      sign = 1'b0;
   endtask

   task automatic test_call();
      boot();
      zero = 1'b1;
      fetch(6'h05, 6'h00, 16'hC001, 26'h0);
      tick(); tick();
      zero = 1'b0;
      n_cmp++; if (pc !== 32'hFFFF_0008) begin n_fail++; $display("FAIL bz_wrap_pc: got %h want %h", pc, 32'hFFFF_0008); end
      fetch(6'h04, 6'h00, 16'h0, 26'h4);
      tick(); tick();
      n_cmp++; if (pc !== 32'hF000_0010) begin n_fail++; $display("FAIL jmp_region_pc: got %h want %h", pc, 32'hF000_0010); end
      fetch(6'h06, 6'h00, 16'h0, 26'h40);
      tick();
      n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL call_exec_rw: got %b want 0", reg_write); end
      tick();
      n_cmp++; if ({reg_write, reg_dest, mem_to_reg} !== 5'b1_10_10 || pc !== 32'hF000_0010) begin n_fail++; $display("FAIL call_wb: got rw=%b rd=%0d m2r=%0d pc=%h want 1 2 2 f0000010", reg_write, reg_dest, mem_to_reg, pc); end
      tick();
      n_cmp++; if (pc !== 32'hF000_0100 || reg_write !== 1'b0) begin n_fail++; $display("FAIL call_pc: got pc=%h rw=%b want f0000100 0", pc, reg_write); end
   endtask

   task automatic test_halt();
      boot();
      fetch(6'h20, 6'h00, 16'h0, 26'h0);
      tick(); tick();
      n_cmp++; if (pc !== 32'h4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL nop_pc: got pc=%h req=%b want 4 1", pc, imem_req); end
`ifdef RISC_SEQ_PERF_EN
      n_cmp++; if (retired_cnt !== 32'd1) begin n_fail++; $display("FAIL nop_retired: got %0d want 1", retired_cnt); end
`endif
      fetch(6'h3F, 6'h00, 16'h0, 26'h0);
      tick();
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got halted=%b busy=%b want 1 0", halted, busy); end
`ifdef RISC_SEQ_PERF_EN
      n_cmp++; if (cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL halt_cycles: got %0d want 5", cycle_cnt); end
`endif
      for (int i = 0; i < 20; i++) begin
         start = 1'b1; imem_ack = i[0]; dmem_ack = ~i[0];
         tick();
         n_cmp++; if (pc !== 32'h4 || halted !== 1'b1 || {imem_req, dmem_req, reg_write, mem_write, ir_load} !== 5'b0) begin n_fail++; $display("FAIL halt_hold_%0d: got pc=%h halted=%b strobes=%b want 4 1 00000", i, pc, halted, {imem_req, dmem_req, reg_write, mem_write, ir_load}); end
      end
      start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
`ifdef RISC_SEQ_PERF_EN
      n_cmp++; if (retired_cnt !== 32'd1 || cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL halt_counters: got ret=%0d cyc=%0d want 1 5", retired_cnt, cycle_cnt); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rtype();
      test_load_store();
      test_branch();
      test_call();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
